// File: rtl/stage_if_prefetch_pkg.sv
// stage_if_prefetch_pkg: shared fetch-stage state encoding
package stage_if_prefetch_pkg;
  typedef enum logic [1:0] {
    IF_IDLE = 2'd0,
    IF_REQ  = 2'd1,
    IF_WAIT = 2'd2
  } if_state_e;
endpackage

// File: rtl/stage_if_prefetch_fifo.sv
// stage_if_prefetch_fifo: sync FIFO with flush; caller never pushes when full or pops when empty
module stage_if_prefetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           data_i,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH):0]     count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, rd_q;
  logic [CW-1:0]    count_q;
  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q] <= data_i;
  always_ff @(posedge clk)
    if (rst || flush_i) begin
      wr_q    <= '0;
      rd_q    <= '0;
      count_q <= '0;
    end else begin
      wr_q    <= wr_q + AW'(push_i);
      rd_q    <= rd_q + AW'(pop_i);
      count_q <= count_q + CW'(push_i) - CW'(pop_i);
    end
  assign data_o  = mem_q[rd_q];
  assign count_o = count_q;
endmodule

// File: rtl/stage_if_prefetch.sv
// stage_if_prefetch: sequential instruction fetch into a DEPTH-entry prefetch queue,
// one request outstanding, redirect flushes the queue and drops the in-flight response
module stage_if_prefetch
  import stage_if_prefetch_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter int                PC_STEP  = 4
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_gnt_i,
  input  logic              mem_rvalid_i,
  input  logic [INST_W-1:0] mem_rdata_i,
  input  logic              br_i,
  input  logic [ADDR_W-1:0] br_target_i,
  output logic              id_valid_o,
  input  logic              id_ready_i,
  output logic [ADDR_W-1:0] id_pc_o,
  output logic [INST_W-1:0] id_inst_o,
  output logic              stallreq_o
);
  localparam int CW = $clog2(DEPTH) + 1;
  if_state_e                state_q, state_d;
  logic [ADDR_W-1:0]        fetch_pc_q, fetch_pc_d, issued_pc_q, issued_pc_d;
  logic                     discard_q, discard_d;
  logic [CW-1:0]            count, cnt_nxt;
  logic                     push, pop;
  logic [ADDR_W+INST_W-1:0] head;
  assign id_valid_o = count != '0;
  assign stallreq_o = !id_valid_o;
  assign pop        = id_valid_o && id_ready_i && !br_i;
  assign push       = state_q == IF_WAIT && mem_rvalid_i && !discard_q && !br_i;
  assign cnt_nxt    = br_i ? '0 : count + CW'(push) - CW'(pop);
  assign mem_req_o  = state_q == IF_REQ;
  assign mem_addr_o = mem_req_o ? fetch_pc_q : '0;
  assign id_pc_o    = id_valid_o ? head[ADDR_W+INST_W-1:INST_W] : '0;
  assign id_inst_o  = id_valid_o ? head[INST_W-1:0] : '0;
  stage_if_prefetch_fifo #(.WIDTH(ADDR_W + INST_W), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .flush_i (br_i),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  ({issued_pc_q, mem_rdata_i}),
    .data_o  (head),
    .count_o (count)
  );
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    issued_pc_d = issued_pc_q;
    discard_d   = discard_q;
    case (state_q)
      IF_IDLE: state_d = count < CW'(DEPTH) ? IF_REQ : IF_IDLE;
      IF_REQ:
        if (mem_gnt_i) begin
          state_d     = IF_WAIT;
          issued_pc_d = fetch_pc_q;
          fetch_pc_d  = fetch_pc_q + ADDR_W'(PC_STEP);
          discard_d   = br_i;
        end
      IF_WAIT:
        if (mem_rvalid_i) begin
          discard_d = 1'b0;
          state_d   = cnt_nxt < CW'(DEPTH) ? IF_REQ : IF_IDLE;
        end else if (br_i) discard_d = 1'b1;
      default: state_d = IF_IDLE;
    endcase
    // a redirect wins over the sequential increment
    if (br_i) fetch_pc_d = {br_target_i[ADDR_W-1:2], 2'b00};
  end
  always_ff @(posedge clk)
    if (rst) begin
      state_q     <= IF_IDLE;
      fetch_pc_q  <= RESET_PC;
      issued_pc_q <= '0;
      discard_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      issued_pc_q <= issued_pc_d;
      discard_q   <= discard_d;
    end
endmodule

// File: tb/tb_stage_if_prefetch.sv
// tb_stage_if_prefetch: random memory/ID/redirect traffic against a queue-level fetch model
module tb_stage_if_prefetch;
  localparam int DEPTH = 4;
  typedef struct {logic [31:0] pc; logic [31:0] inst;} ent_t;
  logic clk = 1'b0, rst = 1'b1;
  logic mem_req_o, mem_gnt_i = 1'b0, mem_rvalid_i = 1'b0;
  logic [31:0] mem_addr_o, mem_rdata_i = '0;
  logic br_i = 1'b0;
  logic [31:0] br_target_i = '0;
  logic id_valid_o, id_ready_i = 1'b0, stallreq_o;
  logic [31:0] id_pc_o, id_inst_o;
  int total = 0, bad = 0;
  ent_t q[$];
  logic [31:0] pop_pc[$], pop_inst[$], gnt_log[$];
  logic [31:0] next_req = '0, pend_addr = '0, force_tgt = '0;
  logic pend = 0, pend_stale = 0, was_rst = 0, force_rst = 0, force_br = 0;
  int pend_lat = 0, idle_run = 0, n_gnt = 0;
  int gnt_pct = 100, lat_lo = 0, lat_hi = 0, br_pct = 0, rdy_pct = 100, rst_pm = 0;

  stage_if_prefetch #(.ADDR_W(32), .INST_W(32), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_STEP(4)) dut (
    .clk(clk), .rst(rst), .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o), .mem_gnt_i(mem_gnt_i),
    .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .br_i(br_i), .br_target_i(br_target_i),
    .id_valid_o(id_valid_o), .id_ready_i(id_ready_i), .id_pc_o(id_pc_o), .id_inst_o(id_inst_o),
    .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] memfn(input logic [31:0] a);
    return a ^ 32'hDEAD_0000;
  endfunction

  function automatic logic [31:0] at(input logic [31:0] qq[$], input int i);
    return i < qq.size() ? qq[i] : 32'hFFFF_FFFF;
  endfunction

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic compare();
    ent_t h;
    logic ev;
    ev = q.size() != 0;
    if (ev) h = q[0];
    else h = '{32'h0, 32'h0};
    chk("id_valid", id_valid_o, ev);
    chk("stallreq", stallreq_o, !ev);
    chk("id_pc", id_pc_o, h.pc);
    chk("id_inst", id_inst_o, h.inst);
    if (was_rst) begin
      chk("rst_req", mem_req_o, 0);
      chk("rst_addr", mem_addr_o, 0);
    end else if (mem_req_o) begin
      chk("req_addr", mem_addr_o, next_req);
      chk("one_outstanding", pend, 0);
      chk("req_space", q.size() < DEPTH, 1);
    end
    idle_run = (!was_rst && !mem_req_o && !pend && q.size() < DEPTH) ? idle_run + 1 : 0;
    chk("fetch_liveness", idle_run > 2, 0);
  endtask

  task automatic step();
    logic r, b, g, v, y, do_pop;
    logic [31:0] t;
    r = force_rst || ($urandom_range(0, 999) < rst_pm);
    b = !r && (force_br || $urandom_range(0, 99) < br_pct);
    t = force_br ? force_tgt : $urandom;
    g = !r && mem_req_o && !pend && ($urandom_range(0, 99) < gnt_pct);
    v = !r && pend && pend_lat == 0;
    y = $urandom_range(0, 99) < rdy_pct;
    force_rst = 0;
    force_br = 0;
    rst = r; br_i = b; br_target_i = t; mem_gnt_i = g; mem_rvalid_i = v; id_ready_i = y;
    mem_rdata_i = v ? memfn(pend_addr) : $urandom;
    was_rst = r;
    if (r) begin
      q.delete();
      next_req = 32'h0;
      pend = 0;
    end else begin
      do_pop = !b && y && q.size() != 0;
      if (do_pop) begin
        pop_pc.push_back(q[0].pc);
        pop_inst.push_back(q[0].inst);
      end
      if (v) begin
        if (!pend_stale && !b) q.push_back('{pend_addr, memfn(pend_addr)});
        pend = 0;
      end else if (pend) pend_lat--;
      if (do_pop) void'(q.pop_front());
      if (g) begin
        pend = 1;
        pend_addr = next_req;
        pend_lat = $urandom_range(lat_lo, lat_hi);
        pend_stale = b;
        next_req += 4;
        gnt_log.push_back(pend_addr);
        n_gnt++;
      end
      if (b) begin
        q.delete();
        next_req = {t[31:2], 2'b00};
        if (pend) pend_stale = 1;
      end
    end
    @(negedge clk);
    compare();
  endtask

  task automatic knobs(input int g, input int lo, input int hi, input int b, input int r, input int rp);
    gnt_pct = g; lat_lo = lo; lat_hi = hi; br_pct = b; rdy_pct = r; rst_pm = rp;
  endtask

  task automatic reset_dut();
    for (int i = 0; i < 2; i++) begin
      force_rst = 1;
      step();
    end
    pop_pc.delete(); pop_inst.delete(); gnt_log.delete(); n_gnt = 0;
  endtask

  task automatic chk_reset_outputs(input string n);
    chk({n, "_req"}, mem_req_o, 0);
    chk({n, "_addr"}, mem_addr_o, 0);
    chk({n, "_valid"}, id_valid_o, 0);
    chk({n, "_pc"}, id_pc_o, 0);
    chk({n, "_inst"}, id_inst_o, 0);
    chk({n, "_stall"}, stallreq_o, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // 1: reset values, first request, sequential stream
    knobs(100, 0, 0, 0, 100, 0);
    reset_dut();
    chk_reset_outputs("t1_rst");
    step();
    chk("t1_first_req", mem_req_o, 1);
    chk("t1_first_addr", mem_addr_o, 32'h0);
    for (int i = 0; i < 12; i++) step();
    chk("t1_pop0", at(pop_pc, 0), 32'h0);
    chk("t1_pop1", at(pop_pc, 1), 32'h4);
    chk("t1_pop2", at(pop_pc, 2), 32'h8);
    chk("t1_inst1", at(pop_inst, 1), 32'hDEAD_0004);
    // 2: ID stalled fills exactly DEPTH, one pop admits one more fetch
    knobs(100, 0, 1, 0, 0, 0);
    reset_dut();
    for (int i = 0; i < 20; i++) step();
    chk("t2_grants", n_gnt, 4);
    chk("t2_req_idle", mem_req_o, 0);
    rdy_pct = 100;
    step();
    rdy_pct = 0;
    n_gnt = 0;
    for (int i = 0; i < 10; i++) step();
    chk("t2_refill", n_gnt, 1);
    // 3: redirect while waiting for pc 0x10
    knobs(100, 3, 3, 0, 100, 0);
    reset_dut();
    for (int n = 0; n < 200 && !(gnt_log.size() > 0 && gnt_log[gnt_log.size()-1] == 32'h10); n++) step();
    chk("t3_reach_0x10", pend && pend_lat > 0, 1);
    pop_pc.delete();
    force_br = 1;
    force_tgt = 32'h100;
    step();
    for (int i = 0; i < 20; i++) step();
    chk("t3_pop0", at(pop_pc, 0), 32'h100);
    chk("t3_pop1", at(pop_pc, 1), 32'h104);
    // 4: redirect with rvalid and pop at count 2
    knobs(100, 0, 0, 0, 0, 0);
    reset_dut();
    for (int n = 0; n < 100 && !(q.size() == 2 && pend && pend_lat == 0); n++) step();
    chk("t4_setup", q.size() == 2 && pend && pend_lat == 0, 1);
    gnt_log.delete();
    rdy_pct = 100;
    force_br = 1;
    force_tgt = 32'h203;
    step();
    chk("t4_flushed", id_valid_o, 0);
    for (int i = 0; i < 4; i++) step();
    chk("t4_target", at(gnt_log, 0), 32'h200);
    // 5: redirect during REQ while grant is withheld
    knobs(0, 0, 0, 0, 100, 0);
    reset_dut();
    step();
    force_br = 1;
    force_tgt = 32'h300;
    step();
    step();
    step();
    chk("t5_req_held", mem_req_o, 1);
    chk("t5_addr_switched", mem_addr_o, 32'h300);
    gnt_log.delete();
    pop_pc.delete();
    gnt_pct = 100;
    for (int i = 0; i < 6; i++) step();
    chk("t5_gnt0", at(gnt_log, 0), 32'h300);
    chk("t5_pop0", at(pop_pc, 0), 32'h300);
    // 6: reset in the middle of a wait
    knobs(100, 3, 3, 0, 100, 0);
    reset_dut();
    for (int n = 0; n < 50 && !(pend && pend_lat >= 2); n++) step();
    chk("t6_setup", pend, 1);
    force_rst = 1;
    step();
    chk_reset_outputs("t6_rst");
    step();
    chk("t6_refetch_req", mem_req_o, 1);
    chk("t6_refetch_addr", mem_addr_o, 32'h0);
    // random traffic
    knobs(70, 0, 3, 5, 60, 3);
    for (int i = 0; i < 2500; i++) step();
    knobs(100, 0, 0, 2, 90, 0);
    for (int i = 0; i < 2500; i++) step();
    knobs(40, 1, 4, 10, 20, 2);
    for (int i = 0; i < 2500; i++) step();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
